// File: rtl/sdram_bank_ctrl.sv
// sdram_bank_ctrl: single-bank SDRAM model with a valid/ready request port,
// split read/write data buses and a refresh FSM that stalls requests via req_ready.
// Optional feature macro: SDRAM_BYTE_MASK_EN (per-byte write enables through req_be).
module sdram_bank_ctrl #(
    parameter  int DATA_WIDTH       = 32,
    parameter  int ROWS             = 8192,
    parameter  int REFRESH_INTERVAL = 1023,
    parameter  int REFRESH_CYCLES   = 8,
    localparam int ADDR_W           = $clog2(ROWS),
    localparam int BE_W             = DATA_WIDTH / 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [BE_W-1:0]       req_be,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  refresh_active,
    output logic [ADDR_W-1:0]     refresh_row
);

    localparam int CNT_W = $clog2(REFRESH_INTERVAL + 1);
    localparam int RC_W  = $clog2(REFRESH_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_INTERVAL - 1);
    localparam logic [RC_W-1:0]   RC_LAST  = RC_W'(REFRESH_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROWS - 1);
    localparam logic [ADDR_W:0]   ROWS_EXT = (ADDR_W + 1)'(ROWS);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_REFRESH = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  pending_q, pending_d;
    logic [RC_W-1:0]       rcnt_q, rcnt_d;
    logic [ADDR_W-1:0]     row_q, row_d;
    logic                  active_q, active_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

    logic [DATA_WIDTH-1:0] mem_q [0:ROWS-1];

    logic                  ready_s;
    logic                  accept_s;
    logic                  rd_accept_s;
    logic                  wr_en_s;
    logic                  addr_ok_s;
    logic [DATA_WIDTH-1:0] rd_row_s;
    logic [DATA_WIDTH-1:0] wr_row_s;

    // Handshake: the bank is free only in IDLE with no refresh waiting.
    assign ready_s     = (state_q == ST_IDLE) && !pending_q;
    assign accept_s    = req_valid && ready_s;
    assign rd_accept_s = accept_s && !req_write;
    // Rows beyond ROWS (non-power-of-two banks) read as zero and ignore writes.
    assign addr_ok_s   = ({1'b0, req_addr} < ROWS_EXT);
    assign wr_en_s     = accept_s && req_write && addr_ok_s;
    assign rd_row_s    = addr_ok_s ? mem_q[req_addr] : {DATA_WIDTH{1'b0}};

`ifdef SDRAM_BYTE_MASK_EN
    if ((DATA_WIDTH % 8) != 0) begin : g_width_check
        $error("sdram_bank_ctrl: DATA_WIDTH must be a multiple of 8 with byte masking");
    end

    // Merge new bytes with the current row contents according to req_be.
    always_comb begin
        wr_row_s = rd_row_s;
        for (int b = 0; b < BE_W; b++) begin
            if (req_be[b]) begin
                wr_row_s[8*b +: 8] = req_wdata[8*b +: 8];
            end else begin
                wr_row_s[8*b +: 8] = rd_row_s[8*b +: 8];
            end
        end
    end
`else
    logic unused_be_s;
    assign unused_be_s = ^req_be;
    assign wr_row_s    = req_wdata;
`endif

    // Next-state logic for the refresh FSM, interval counter and read response.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pending_d    = pending_q;
        rcnt_d       = rcnt_q;
        row_d        = row_q;
        active_d     = active_q;
        resp_valid_d = rd_accept_s;
        resp_rdata_d = rd_accept_s ? rd_row_s : resp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                // Count towards the next refresh and saturate on the last value.
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = cnt_q;
                    pending_d = 1'b1;
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    pending_d = pending_q;
                end
                // Enter REFRESH on the same edge the refresh becomes pending,
                // so a read accepted in this cycle still answers next cycle.
                if (pending_d) begin
                    state_d  = ST_REFRESH;
                    active_d = 1'b1;
                    rcnt_d   = {RC_W{1'b0}};
                end else begin
                    state_d  = ST_IDLE;
                    active_d = 1'b0;
                    rcnt_d   = rcnt_q;
                end
            end
            ST_REFRESH: begin
                if (rcnt_q == RC_LAST) begin
                    state_d   = ST_IDLE;
                    active_d  = 1'b0;
                    rcnt_d    = {RC_W{1'b0}};
                    pending_d = 1'b0;
                    cnt_d     = {CNT_W{1'b0}};
                    row_d     = (row_q == ROW_LAST) ? {ADDR_W{1'b0}} : row_q + ADDR_W'(1);
                end else begin
                    rcnt_d    = rcnt_q + RC_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                active_d  = 1'b0;
                rcnt_d    = {RC_W{1'b0}};
                pending_d = 1'b0;
                cnt_d     = {CNT_W{1'b0}};
            end
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            pending_q    <= 1'b0;
            rcnt_q       <= {RC_W{1'b0}};
            // An aborted refresh leaves the row pointer where it was.
            row_q        <= (state_q == ST_REFRESH) ? row_q : {ADDR_W{1'b0}};
            active_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            rcnt_q       <= rcnt_d;
            row_q        <= row_d;
            active_q     <= active_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Row storage; contents survive reset like a real array.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            mem_q[req_addr] <= wr_row_s;
        end
    end

    assign req_ready      = ready_s;
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign refresh_active = active_q;
    assign refresh_row    = row_q;

endmodule

// File: tb/tb_sdram_bank_ctrl.sv
// Directed self-checking bench for sdram_bank_ctrl (ROWS=16, interval 20, refresh 4 cycles).
// Cycle 0 is the first cycle after reset has been sampled; values are checked 1 time unit
// after each rising edge.
module tb_sdram_bank_ctrl;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [3:0]    req_be;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          refresh_active;
    logic [AW-1:0] refresh_row;

    int checks = 0;
    int errors = 0;

    sdram_bank_ctrl #(
        .DATA_WIDTH       (32),
        .ROWS             (16),
        .REFRESH_INTERVAL (20),
        .REFRESH_CYCLES   (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_be         (req_be),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .refresh_active (refresh_active),
        .refresh_row    (refresh_row)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 4'd0;
        req_wdata = 32'd0;
        req_be    = 4'hF;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drive(input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [3:0] be);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = data;
        req_be    = be;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        checks++;
        if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata got %h want 00000000", resp_rdata); end
        checks++;
        if (refresh_active !== 1'b0) begin errors++; $display("FAIL reset_refresh_active got %b want 0", refresh_active); end
        checks++;
        if (refresh_row !== 4'd0) begin errors++; $display("FAIL reset_refresh_row got %0d want 0", refresh_row); end
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    endtask

    task automatic test_write_read();
        do_reset();
        drive(1'b1, 4'd3, 32'hDEADBEEF, 4'hF);   // cycle 0
        tick();                                  // cycle 1
        checks++;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL wr_no_resp got %b want 0", resp_valid); end
        drive(1'b0, 4'd3, 32'h0, 4'hF);
        tick();                                  // cycle 2
        req_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b1) begin errors++; $display("FAIL rd_resp_valid got %b want 1", resp_valid); end
        checks++;
        if (resp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_resp_data got %h want deadbeef", resp_rdata); end
        tick();                                  // cycle 3
        checks++;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL rd_resp_pulse got %b want 0", resp_valid); end
        checks++;
        if (resp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data_hold got %h want deadbeef", resp_rdata); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, 4'd5, 32'h11111111, 4'hF);   // cycle 0
        tick();
        drive(1'b1, 4'd6, 32'h22222222, 4'hF);   // cycle 1
        tick();
        drive(1'b0, 4'd5, 32'h0, 4'hF);          // cycle 2
        tick();
        drive(1'b0, 4'd6, 32'h0, 4'hF);          // cycle 3
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h11111111) begin
            errors++; $display("FAIL b2b_first got %b/%h want 1/11111111", resp_valid, resp_rdata);
        end
        tick();                                  // cycle 4
        req_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h22222222) begin
            errors++; $display("FAIL b2b_second got %b/%h want 1/22222222", resp_valid, resp_rdata);
        end
        tick();                                  // cycle 5
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'h22222222) begin
            errors++; $display("FAIL b2b_idle got %b/%h want 0/22222222", resp_valid, resp_rdata);
        end
    endtask

    task automatic test_byte_mask();
        logic [DW-1:0] exp;
`ifdef SDRAM_BYTE_MASK_EN
        exp = 32'hFF00FF00;
`else
        exp = 32'h00000000;
`endif
        do_reset();
        drive(1'b1, 4'd2, 32'hFFFFFFFF, 4'hF);   // cycle 0
        tick();
        drive(1'b1, 4'd2, 32'h00000000, 4'b0101);
        tick();
        drive(1'b0, 4'd2, 32'h0, 4'hF);
        tick();
        req_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== exp) begin
            errors++; $display("FAIL byte_mask got %b/%h want 1/%h", resp_valid, resp_rdata, exp);
        end
    endtask

    task automatic test_refresh_timing();
        logic exp_active;
        logic exp_ready;
        logic [AW-1:0] exp_row;
        do_reset();
        for (int c = 0; c <= 24; c++) begin
            exp_active = (c >= 20) && (c <= 23);
            exp_row    = (c >= 24) ? 4'd1 : 4'd0;
            checks++;
            if (refresh_active !== exp_active) begin
                errors++; $display("FAIL refresh_active c%0d got %b want %b", c, refresh_active, exp_active);
            end
            checks++;
            if (refresh_row !== exp_row) begin
                errors++; $display("FAIL refresh_row c%0d got %0d want %0d", c, refresh_row, exp_row);
            end
            if (c <= 18 || c >= 20) begin
                exp_ready = !exp_active;
                checks++;
                if (req_ready !== exp_ready) begin
                    errors++; $display("FAIL req_ready c%0d got %b want %b", c, req_ready, exp_ready);
                end
            end
            if (c < 24) tick();
        end
    endtask

    task automatic test_read_before_refresh();
        do_reset();
        drive(1'b1, 4'd8, 32'h0BADF00D, 4'hF);   // cycle 0
        tick();
        req_valid = 1'b0;
        repeat (18) tick();                      // cycle 19
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL pre_refresh_ready got %b want 1", req_ready); end
        drive(1'b0, 4'd8, 32'h0, 4'hF);
        tick();                                  // cycle 20
        req_valid = 1'b0;
        checks++;
        if (refresh_active !== 1'b1) begin errors++; $display("FAIL pre_refresh_active got %b want 1", refresh_active); end
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h0BADF00D) begin
            errors++; $display("FAIL pre_refresh_resp got %b/%h want 1/0badf00d", resp_valid, resp_rdata);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL pre_refresh_pulse got %b want 0", resp_valid); end
    endtask

    task automatic test_refresh_stall();
        int acc_c;
        int rsp_c;
        int rsp_n;
        logic [DW-1:0] got;
        acc_c = -1;
        rsp_c = -1;
        rsp_n = 0;
        got   = 32'h0;
        do_reset();
        drive(1'b1, 4'd7, 32'hA5A55A5A, 4'hF);   // cycle 0
        tick();
        req_valid = 1'b0;
        repeat (19) tick();                      // cycle 20
        drive(1'b0, 4'd7, 32'h0, 4'hF);
        for (int c = 20; c <= 28; c++) begin
            if (resp_valid) begin
                rsp_n++;
                rsp_c = c;
                got   = resp_rdata;
            end
            if (req_valid && req_ready) acc_c = c;
            tick();
            if (acc_c >= 0) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        checks++;
        if (acc_c !== 24) begin errors++; $display("FAIL stall_accept_cycle got %0d want 24", acc_c); end
        checks++;
        if (rsp_c !== 25) begin errors++; $display("FAIL stall_resp_cycle got %0d want 25", rsp_c); end
        checks++;
        if (rsp_n !== 1) begin errors++; $display("FAIL stall_resp_count got %0d want 1", rsp_n); end
        checks++;
        if (got !== 32'hA5A55A5A) begin errors++; $display("FAIL stall_resp_data got %h want a5a55a5a", got); end
    endtask

    task automatic test_refresh_wrap();
        logic prev;
        int n;
        prev = 1'b0;
        n    = 0;
        do_reset();
        for (int c = 0; c < 600 && n < 16; c++) begin
            if (prev && !refresh_active) begin
                n++;
                if (n == 15) begin
                    checks++;
                    if (refresh_row !== 4'd15) begin errors++; $display("FAIL wrap_row15 got %0d want 15", refresh_row); end
                end
                if (n == 16) begin
                    checks++;
                    if (refresh_row !== 4'd0) begin errors++; $display("FAIL wrap_row0 got %0d want 0", refresh_row); end
                end
            end
            prev = refresh_active;
            if (n < 16) tick();
        end
        checks++;
        if (n !== 16) begin errors++; $display("FAIL wrap_refresh_count got %0d want 16 (timeout)", n); end
    endtask

    task automatic test_reset_abort();
        do_reset();
        repeat (21) tick();                      // cycle 21, second REFRESH cycle
        checks++;
        if (refresh_active !== 1'b1) begin errors++; $display("FAIL abort_pre_active got %b want 1", refresh_active); end
        reset = 1'b1;
        tick();                                  // cycle 22
        reset = 1'b0;
        checks++;
        if (refresh_active !== 1'b0) begin errors++; $display("FAIL abort_active got %b want 0", refresh_active); end
        checks++;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL abort_resp_valid got %b want 0", resp_valid); end
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", req_ready); end
        checks++;
        if (refresh_row !== 4'd0) begin errors++; $display("FAIL abort_row got %0d want 0", refresh_row); end
        repeat (19) tick();                      // cycle 41: counter restarted at 0 in cycle 22
        checks++;
        if (refresh_active !== 1'b0) begin errors++; $display("FAIL abort_counter_early got %b want 0", refresh_active); end
        tick();                                  // cycle 42
        checks++;
        if (refresh_active !== 1'b1) begin errors++; $display("FAIL abort_counter_restart got %b want 1", refresh_active); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_byte_mask();
        test_refresh_timing();
        test_read_before_refresh();
        test_refresh_stall();
        test_refresh_wrap();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
